// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder with programmable wait states and a
//                one-cycle ready/error completion strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 7,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       mem_in,
    output logic [31:0]       mem_out,
    output logic              mem_ready,
    output logic              err
);

    localparam int         c_IDX_W    = ADDR_W - 2;
    localparam int         c_WIDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]          r_cnt;
    logic                r_rd;
    logic                r_wr;
    logic                r_err;
    logic [c_WIDX_W-1:0] r_widx;
    logic [31:0]         r_data;
    logic [31:0]         r_mem [DEPTH];

    logic                w_req;
    logic [c_IDX_W-1:0]  w_in_idx;
    logic [c_WIDX_W-1:0] w_in_widx;
    logic                w_oor;
    logic                w_in_err;
    logic                w_use_in;
    logic                w_c_rd;
    logic                w_c_wr;
    logic                w_c_err;
    logic [c_WIDX_W-1:0] w_c_widx;
    logic [31:0]         w_c_data;
    logic                w_commit;

    assign w_req    = mem_read | mem_write;
    assign w_in_idx = address[ADDR_W-1:2];

    // DEPTH is a power of two, so an out-of-range index shows up as set upper bits.
    if (c_IDX_W > c_WIDX_W) begin : g_range_chk
        assign w_in_widx = w_in_idx[c_WIDX_W-1:0];
        assign w_oor     = |w_in_idx[c_IDX_W-1:c_WIDX_W];
    end else begin : g_no_range_chk
        assign w_in_widx = c_WIDX_W'(w_in_idx);
        assign w_oor     = 1'b0;
    end

    assign w_in_err = (address[1:0] != 2'b00) | w_oor | (mem_read & mem_write);

    // With zero wait states DONE is entered straight from IDLE, before the
    // latched copies exist, so the commit takes the live port values instead.
    assign w_use_in = (r_state == IDLE);
    assign w_c_rd   = w_use_in ? mem_read  : r_rd;
    assign w_c_wr   = w_use_in ? mem_write : r_wr;
    assign w_c_err  = w_use_in ? w_in_err  : r_err;
    assign w_c_widx = w_use_in ? w_in_widx : r_widx;
    assign w_c_data = w_use_in ? mem_in    : r_data;
    assign w_commit = (w_next == DONE) && (r_state != DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = (WAIT_STATES == 0) ? DONE : BUSY;
            BUSY:    if (r_cnt == 4'd0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_widx  <= '0;
            r_data  <= 32'd0;
            mem_out <= 32'd0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_rd   <= mem_read;
                r_wr   <= mem_write;
                r_err  <= w_in_err;
                r_widx <= w_in_widx;
                r_data <= mem_in;
                r_cnt  <= c_CNT_INIT;
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !w_c_err) begin
                if (w_c_wr) r_mem[w_c_widx] <= w_c_data;
                if (w_c_rd) mem_out <= r_mem[w_c_widx];
            end
        end
    end

    assign mem_ready = (r_state == DONE);
    assign err       = (r_state == DONE) & r_err;

endmodule
`default_nettype wire
